// File: rtl/fifo_pkg.sv
// Shared constants, pointer type and mod-3 pointer arithmetic for the FIFO read-stream path.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUF_DEPTH      = 3;

    typedef logic [1:0] ptr_t;

    // Pointers walk 0,1,2,0,... because the buffer depth is not a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p == ptr_t'(BUF_DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Three-entry register buffer with head/tail pointers; head entry is presented combinationally.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            level
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    ptr_t                  head_q, head_d;
    ptr_t                  tail_q, tail_d;
    logic [1:0]            level_q, level_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            // Push and pop together leave the level unchanged.
            case ({push, pop})
                2'b10:   level_d = level_q + 2'd1;
                2'b01:   level_d = level_q - 2'd1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (push && !clear && (tail_q == ptr_t'(gi))) begin
                    mem_q[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign head_data = mem_q[head_q];
    assign level     = level_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Pulls words from the fifo block and re-presents them as a valid/ready stream through a 3-deep buffer.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [1:0]            buf_level,
    output logic [CNT_WIDTH-1:0]  words_out
);

    logic                 inflight_q;
    logic [CNT_WIDTH-1:0] words_q, words_d;
    logic [1:0]           level;
    logic [2:0]           pending;
    logic                 push;
    logic                 xfer;

    // Issue only from registered state so m_ready never reaches fifo_rd_en.
    assign pending    = {1'b0, level} + {2'b00, inflight_q};
    assign fifo_rd_en = !rst && !flush && !fifo_empty && (pending < 3'(BUF_DEPTH));

    assign m_valid = (level != 2'd0);
    assign push    = inflight_q && !flush;
    assign xfer    = m_valid && m_ready && !flush;
    assign words_d = xfer ? words_q + 1'b1 : words_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            words_q    <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            words_q    <= words_d;
        end
    end

    rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (fifo_data_out),
        .pop       (xfer),
        .head_data (m_data),
        .level     (level)
    );

    assign buf_level = level;
    assign words_out = words_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO and an output transfer monitor.
module tb_fifo_rd_stream;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          flush;
    logic [1:0]    buf_level;
    logic [CW-1:0] words_out;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fifo_mem [0:63];
    int            wr_cnt    = 0;
    int            rd_cnt    = 0;
    int            rd_pulses = 0;
    int            cyc       = 0;
    logic          inflight_m = 1'b0;
    logic [DW-1:0] out_q [$];
    int            out_cyc [$];

    always #5 clk = ~clk;

    assign fifo_empty = (rd_cnt == wr_cnt);

    fifo_rd_stream #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_rd_en   (fifo_rd_en),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .flush        (flush),
        .buf_level    (buf_level),
        .words_out    (words_out)
    );

    // Behavioural FIFO: data appears the cycle after an accepted read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        inflight_m <= rst ? 1'b0 : (fifo_rd_en && !fifo_empty);
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data_out <= fifo_mem[rd_cnt];
            rd_cnt        <= rd_cnt + 1;
            rd_pulses     <= rd_pulses + 1;
        end else begin
            fifo_data_out <= 8'hEE;
        end
        if (!rst && !flush && m_valid && m_ready) begin
            out_q.push_back(m_data);
            out_cyc.push_back(cyc);
        end
    end

    // A read issued at the last edge must never land while the buffer is already full.
    always @(negedge clk) begin
        if (!rst && inflight_m) begin
            checks++;
            if (buf_level == 2'd3) begin
                failures++;
                $display("FAIL overflow: buf_level=%0d with read in flight, required <=2", buf_level);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [DW-1:0] base, input logic [DW-1:0] stp, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_cnt + i] = 8'(base + i * stp);
        end
        wr_cnt = wr_cnt + n;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
        checks++; if (buf_level !== 2'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", buf_level); end
        checks++; if (words_out !== 16'd0) begin failures++; $display("FAIL reset_words: got %0d expected 0", words_out); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || buf_level !== 2'd0 || words_out !== 16'd0) begin
                failures++;
                $display("FAIL idle c%0d: rd_en=%b valid=%b level=%0d words=%0d expected 0/0/0/0",
                         c, fifo_rd_en, m_valid, buf_level, words_out);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_stream;
        int first_rd = -1;
        int first_v  = -1;
        logic [DW-1:0] exp_w;
        out_q.delete(); out_cyc.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                preload(8'h11, 8'h11, 4);
                m_ready = 1'b1;
            end
            #1;
            if (fifo_rd_en && first_rd < 0) first_rd = c;
            if (m_valid && first_v < 0) first_v = c;
        end
        checks++; if (first_rd !== 0) begin failures++; $display("FAIL stream_first_rd: got cycle %0d expected 0", first_rd); end
        checks++; if (first_v !== 2) begin failures++; $display("FAIL stream_latency: got cycle %0d expected 2", first_v); end
        checks++; if (out_q.size() !== 4) begin failures++; $display("FAIL stream_count: got %0d expected 4", out_q.size()); end
        for (int i = 0; i < 4; i++) begin
            exp_w = 8'(8'h11 * (i + 1));
            checks++;
            if (i >= out_q.size() || out_q[i] !== exp_w) begin
                failures++;
                $display("FAIL stream_word%0d: got %0h expected %0h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp_w);
            end
        end
        checks++;
        if (out_cyc.size() != 4 || (out_cyc[3] - out_cyc[0]) != 3) begin
            failures++;
            $display("FAIL stream_back_to_back: transfers=%0d not on 4 consecutive cycles", out_cyc.size());
        end
        checks++; if (words_out !== 16'd4) begin failures++; $display("FAIL stream_words: got %0d expected 4", words_out); end
        checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL stream_fifo_empty: got %b expected 1", fifo_empty); end
        $display("test_stream done: %0d words", out_q.size());
    endtask

    task automatic test_backpressure;
        int p0 = rd_pulses;
        out_q.delete(); out_cyc.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                preload(8'hA0, 8'h01, 8);
                m_ready = 1'b0;
            end
            #1;
            if (m_valid) begin
                checks++;
                if (m_data !== 8'hA0) begin failures++; $display("FAIL bp_hold c%0d: got %0h expected a0", c, m_data); end
            end
        end
        checks++; if (rd_pulses - p0 !== 3) begin failures++; $display("FAIL bp_pulses: got %0d expected 3", rd_pulses - p0); end
        checks++; if (buf_level !== 2'd3) begin failures++; $display("FAIL bp_level: got %0d expected 3", buf_level); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", m_valid); end
        @(negedge clk);
        m_ready = 1'b1;
        repeat (14) @(negedge clk);
        #1;
        checks++; if (out_q.size() !== 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", out_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== 8'(8'hA0 + i)) begin
                failures++;
                $display("FAIL bp_word%0d: got %0h expected %0h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, 8'(8'hA0 + i));
            end
        end
        checks++; if (rd_pulses - p0 !== 8) begin failures++; $display("FAIL bp_total_pulses: got %0d expected 8", rd_pulses - p0); end
        checks++; if (words_out !== 16'd12) begin failures++; $display("FAIL bp_words: got %0d expected 12", words_out); end
        $display("test_backpressure done: %0d words", out_q.size());
    endtask

    task automatic test_toggle;
        out_q.delete(); out_cyc.delete();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) preload(8'hB0, 8'h01, 6);
            m_ready = (c % 2 == 0);
        end
        #1;
        checks++; if (out_q.size() !== 6) begin failures++; $display("FAIL toggle_count: got %0d expected 6", out_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== 8'(8'hB0 + i)) begin
                failures++;
                $display("FAIL toggle_word%0d: got %0h expected %0h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, 8'(8'hB0 + i));
            end
        end
        checks++; if (words_out !== 16'd18) begin failures++; $display("FAIL toggle_words: got %0d expected 18", words_out); end
        $display("test_toggle done: %0d words", out_q.size());
    endtask

    task automatic test_flush;
        out_q.delete(); out_cyc.delete();
        @(negedge clk);
        m_ready = 1'b0;
        preload(8'hC0, 8'h01, 5);
        #1;
        checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL flush_first_rd: got %b expected 1", fifo_rd_en); end
        repeat (2) @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++; if (buf_level !== 2'd2) begin failures++; $display("FAIL flush_pre_level: got %0d expected 2", buf_level); end
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL flush_rd_en: got %b expected 0", fifo_rd_en); end
        @(negedge clk);
        flush = 1'b0;
        m_ready = 1'b1;
        #1;
        checks++; if (buf_level !== 2'd0) begin failures++; $display("FAIL flush_level: got %0d expected 0", buf_level); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", m_valid); end
        checks++; if (words_out !== 16'd18) begin failures++; $display("FAIL flush_words: got %0d expected 18", words_out); end
        repeat (8) @(negedge clk);
        #1;
        checks++; if (out_q.size() !== 2) begin failures++; $display("FAIL flush_resume_count: got %0d expected 2", out_q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== 8'(8'hC3 + i)) begin
                failures++;
                $display("FAIL flush_word%0d: got %0h expected %0h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, 8'(8'hC3 + i));
            end
        end
        checks++; if (words_out !== 16'd20) begin failures++; $display("FAIL flush_words_after: got %0d expected 20", words_out); end
        $display("test_flush done: %0d words after flush", out_q.size());
    endtask

    task automatic test_reset_mid;
        out_q.delete(); out_cyc.delete();
        @(negedge clk);
        m_ready = 1'b1;
        preload(8'hD0, 8'h01, 6);
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rstmid_rd_en: got %b expected 0", fifo_rd_en); end
        checks++;
        if (out_q.size() !== 2 || out_q[0] !== 8'hD0 || out_q[1] !== 8'hD1) begin
            failures++;
            $display("FAIL rstmid_pre_words: got %0d words expected d0,d1", out_q.size());
        end
        @(negedge clk);
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || buf_level !== 2'd0 || words_out !== 16'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: rd_en=%b valid=%b data=%0h level=%0d words=%0d expected all 0",
                     fifo_rd_en, m_valid, m_data, buf_level, words_out);
        end
        @(negedge clk);
        rst = 1'b0;
        out_q.delete(); out_cyc.delete();
        repeat (8) @(negedge clk);
        #1;
        checks++; if (out_q.size() !== 2) begin failures++; $display("FAIL rstmid_resume_count: got %0d expected 2", out_q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= out_q.size() || out_q[i] !== 8'(8'hD4 + i)) begin
                failures++;
                $display("FAIL rstmid_word%0d: got %0h expected %0h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, 8'(8'hD4 + i));
            end
        end
        checks++; if (words_out !== 16'd2) begin failures++; $display("FAIL rstmid_words: got %0d expected 2", words_out); end
        $display("test_reset_mid done: %0d words after reset", out_q.size());
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's `fifo` block.
- Drives `fifo_rd_en`, watches `fifo_empty` and captures `fifo_data_out`.
- Re-presents the words as a valid/ready stream with a 3-entry elastic buffer.
- Lets downstream logic back-pressure without a combinational path from `m_ready` to `fifo_rd_en`, while sustaining 1 word/cycle.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and `m_data`.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; shared with the `fifo` instance.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted `fifo_rd_en`.
- fifo_rd_en  output  1  FIFO read strobe.
- m_valid  output  1  output word available.
- m_data  output  DATA_WIDTH  output word (head of buffer).
- m_ready  input  1  downstream accept.
- flush  input  1  synchronous discard of buffered and in-flight words.
- buf_level  output  2  current buffer occupancy, 0..3.
- words_out  output  CNT_WIDTH  count of completed output transfers.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; clock port `clk`, reset port `rst`.
- Reset values, applied at the first edge with `rst`=1:
  - `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `buf_level`=0, `words_out`=0.
  - In-flight flag cleared; buffer pointers = 0.
  - `fifo_rd_en` is also forced 0 combinationally while `rst`=1.
- FIFO read timing:
  - `fifo_rd_en` high in cycle t with `fifo_empty`=0 → `fifo_data_out` valid in t+1.
  - The block captures it at the end of t+1.
- State:
  - `occ` (0..3) = number of words held in the buffer.
  - `inflight` (1 bit) = a read was issued last cycle and its data arrives this cycle.
- Issue rule: `fifo_rd_en` = !`rst` & !`flush` & !`fifo_empty` & (`occ` + `inflight` < 3).
  - Uses registered state only; no dependence on `m_ready`.
- Registers:
  - `inflight` <= `fifo_rd_en`.
  - When `inflight`=1, `fifo_data_out` is written at the tail pointer, which then advances mod 3.
- Output:
  - `m_valid` = (`occ` != 0); `m_data` = entry at head pointer.
  - Transfer = `m_valid` & `m_ready`; it advances head mod 3 and increments `words_out`.
- Simultaneous capture and transfer in one cycle: `occ` unchanged, both pointers advance.
- Occupancy never exceeds 3; an attempted capture at `occ`=3 is impossible by the issue rule. The bench asserts this.
- Latency: FIFO non-empty and buffer idle in cycle t → `fifo_rd_en` in t, `m_valid` in t+2.
- Throughput: with `m_ready` held high and the FIFO non-empty, 1 word/cycle is sustained in steady state (`occ`=1, `inflight`=1).
- Back-pressure: `m_ready` low holds `m_data` and `m_valid` stable until the transfer.
- Flush, at the edge with `flush`=1:
  - `occ`, pointers and `inflight` cleared; the returning in-flight word is discarded.
  - `fifo_rd_en`=0 during the flush cycle; `words_out` is unchanged.
  - `flush` takes priority over a same-cycle transfer; that transfer is not counted.
- Empty FIFO: no reads issued; `m_valid` falls once the buffer drains.
- `words_out` wraps modulo 2^CNT_WIDTH.
- Reset mid-stream: in-flight data is discarded, output is deasserted the next cycle, and no `fifo_rd_en` is issued during reset.

Decomposition:
- `fifo_pkg` holds:
  - default DATA_WIDTH;
  - localparam BUF_DEPTH=3;
  - pointer type `ptr_t` (2 bits);
  - a `ptr_inc` function implementing mod-3 wrap.
- One sub-module, `rd_skid_buf`: 3-entry register buffer with head/tail pointers, `push`/`pop`/`clear` inputs and a `level` output.
- The top level holds the issue logic, the `inflight` flag and the counter.

Test Plan:
1. Reset then idle, `fifo_empty`=1 → `fifo_rd_en`=0, `m_valid`=0, `buf_level`=0, `words_out`=0 for 10 cycles.
2. FIFO preloaded with 0x11,0x22,0x33,0x44, `m_ready`=1 → first `m_valid` 2 cycles after the first `fifo_rd_en`; words out in order on 4 consecutive cycles; `words_out`=4; FIFO ends empty.
3. FIFO holds 8 words, `m_ready`=0 → exactly 3 `fifo_rd_en` pulses; `buf_level`=3; `m_data`=first word held stable. Then `m_ready`=1 → the remaining 5 words are read and all 8 are delivered in order.
4. `m_ready` toggling 1,0,1,0 during a 6-word stream → no loss, no duplication, order preserved; `buf_level` ≤ 3 every cycle.
5. `flush` asserted in the cycle after a `fifo_rd_en`, with `buf_level`=2 → next cycle `buf_level`=0 and `m_valid`=0; the in-flight word is dropped; `words_out` unchanged; streaming resumes with the next FIFO word.
6. `rst` asserted while streaming mid-burst → at the next edge all outputs return to reset values; no `fifo_rd_en` while `rst`=1.
